// File: rtl/lsu_bus_ctrl_pkg.sv
// Package: lsu_bus_ctrl_pkg
// Shared definitions for the load/store unit: memory-op codes, FSM state
// encoding, exception cause codes and the op decoder.
//   decode_memop : op code -> {is memory op, store, log2 size, sign-extend}
//   size_lanes   : log2 size -> unshifted byte-lane mask (up to 8 lanes)
package lsu_bus_ctrl_pkg;

  localparam int unsigned MEMOP_NONE = 0;
  localparam int unsigned MEMOP_LB   = 1;
  localparam int unsigned MEMOP_LBU  = 2;
  localparam int unsigned MEMOP_LH   = 3;
  localparam int unsigned MEMOP_LHU  = 4;
  localparam int unsigned MEMOP_LW   = 5;
  localparam int unsigned MEMOP_LWU  = 6;
  localparam int unsigned MEMOP_LD   = 7;
  localparam int unsigned MEMOP_SB   = 8;
  localparam int unsigned MEMOP_SH   = 9;
  localparam int unsigned MEMOP_SW   = 10;
  localparam int unsigned MEMOP_SD   = 11;

  localparam logic [1:0] EXC_NONE        = 2'd0;
  localparam logic [1:0] EXC_ACCESS      = 2'd1;
  localparam logic [1:0] EXC_LD_MISALIGN = 2'd2;
  localparam logic [1:0] EXC_ST_MISALIGN = 2'd3;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} lsu_state_e;

  typedef struct packed {
    logic       mem;   // needs a bus access
    logic       we;    // store
    logic [1:0] size;  // log2 of access size in bytes
    logic       sext;  // sign-extend load result
  } memop_dec_t;

  // Unknown codes, and LD on a 32-bit datapath, decode as NONE.
  function automatic memop_dec_t decode_memop(input int unsigned op, input int unsigned xlen);
    memop_dec_t d;
    d = '0;
    case (op)
      MEMOP_LB:  d = '{mem: 1'b1, we: 1'b0, size: 2'd0, sext: 1'b1};
      MEMOP_LBU: d = '{mem: 1'b1, we: 1'b0, size: 2'd0, sext: 1'b0};
      MEMOP_LH:  d = '{mem: 1'b1, we: 1'b0, size: 2'd1, sext: 1'b1};
      MEMOP_LHU: d = '{mem: 1'b1, we: 1'b0, size: 2'd1, sext: 1'b0};
      MEMOP_LW:  d = '{mem: 1'b1, we: 1'b0, size: 2'd2, sext: 1'b1};
      MEMOP_LWU: d = '{mem: 1'b1, we: 1'b0, size: 2'd2, sext: 1'b0};
      MEMOP_LD: begin
        if (xlen == 64) d = '{mem: 1'b1, we: 1'b0, size: 2'd3, sext: 1'b0};
      end
      MEMOP_SB:  d = '{mem: 1'b1, we: 1'b1, size: 2'd0, sext: 1'b0};
      MEMOP_SH:  d = '{mem: 1'b1, we: 1'b1, size: 2'd1, sext: 1'b0};
      MEMOP_SW:  d = '{mem: 1'b1, we: 1'b1, size: 2'd2, sext: 1'b0};
      MEMOP_SD:  d = '{mem: 1'b1, we: 1'b1, size: 2'd3, sext: 1'b0};
      default:   d = '0;
    endcase
    return d;
  endfunction

  function automatic logic [7:0] size_lanes(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Module: lsu_load_align
// Combinational load data extraction: shifts the full aligned bus word right
// by the byte offset and sign/zero-extends the access-sized field to XLEN.
// Ports:
//   rdata  in  XLEN   full aligned word from the bus
//   offset in  OFF_W  byte offset within the word
//   size   in  2      log2 of access size in bytes
//   sext   in  1      1 = sign-extend, 0 = zero-extend
//   data   out XLEN   extended result
module lsu_load_align #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned OFF_W = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]  rdata,
  input  logic [OFF_W-1:0] offset,
  input  logic [1:0]       size,
  input  logic             sext,
  output logic [XLEN-1:0]  data
);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] keep;
  logic            sign;
  int unsigned     nbits;

  always_comb begin
    // Bytes shifted in from beyond the top lane read as zero.
    shifted = rdata >> {offset, 3'b000};
    nbits   = 32'd8 << size;
    if (nbits > XLEN) nbits = XLEN;
    keep    = (nbits == XLEN) ? '1 : ((XLEN'(1) << nbits) - XLEN'(1));
    sign    = sext & shifted[nbits-1];
    data    = (shifted & keep) | ({XLEN{sign}} & ~keep);
  end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Module: lsu_bus_ctrl
// Load/store unit between execute and writeback. Accepts one op per
// in_valid/in_ready handshake, issues one bus request, waits for the
// response (or timeout) and holds the result until out_ready.
// Optional build macro: LSU_MISALIGN_TRAP_EN -- naturally misaligned accesses
// raise a misaligned exception instead of going to the bus. Without it,
// lanes shifted past the top of the word are dropped.
// Ports:
//   clk, rst (sync, active-low)
//   in_*      op from execute (valid/ready)
//   bus_req_* request channel (valid/ready), aligned addr, lane mask, wdata
//   bus_rsp_* response pulse with read data and error
//   out_*     registered result to writeback (valid/ready)
module lsu_bus_ctrl
  import lsu_bus_ctrl_pkg::*;
#(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned RIDX_W  = 5,
  parameter int unsigned MEMOP_W = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MEMOP_W-1:0]  in_mem_op,
  input  logic [XLEN-1:0]     in_addr,
  input  logic [XLEN-1:0]     in_wdata,
  input  logic [RIDX_W-1:0]   in_rd_idx,
  output logic                bus_req_valid,
  input  logic                bus_req_ready,
  output logic                bus_req_we,
  output logic [XLEN-1:0]     bus_req_addr,
  output logic [XLEN-1:0]     bus_req_wdata,
  output logic [XLEN/8-1:0]   bus_req_mask,
  input  logic                bus_rsp_valid,
  input  logic [XLEN-1:0]     bus_rsp_rdata,
  input  logic                bus_rsp_err,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_data,
  output logic [RIDX_W-1:0]   out_rd_idx,
  output logic                out_is_load,
  output logic                out_exc,
  output logic [1:0]          out_exc_cause
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lsu_state_e        state_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              sext_q;
  logic [OFF_W-1:0]  off_q;
  logic [RIDX_W-1:0] rd_q;
  logic [CNT_W-1:0]  wait_cnt_q;

  memop_dec_t        dec;
  logic [OFF_W-1:0]  in_off;
  logic [7:0]        lanes8;
  logic [NB-1:0]     size_mask;
  logic [XLEN-1:0]   size_bits;
  logic [NB-1:0]     req_mask;
  logic [XLEN-1:0]   req_wdata;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   load_data;
  logic              rsp_fire;
  logic              timeout_hit;
  logic              fault;

  always_comb begin
    dec       = decode_memop(32'(in_mem_op), XLEN);
    in_off    = in_addr[OFF_W-1:0];
    lanes8    = size_lanes(dec.size);
    size_mask = lanes8[NB-1:0];
    for (int i = 0; i < NB; i++) size_bits[8*i +: 8] = {8{size_mask[i]}};
    // Left shifts truncate at the top lane: straddling bytes are dropped.
    req_mask  = size_mask << in_off;
    req_wdata = (in_wdata & size_bits) << {in_off, 3'b000};
    req_addr  = in_addr & ~XLEN'(NB - 1);
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic [OFF_W-1:0] align_lo;
  logic             misalign;
  always_comb begin
    align_lo = OFF_W'((8'd1 << dec.size) - 8'd1);
    misalign = |(in_off & align_lo);
  end
`endif

  // A response in REQ counts only together with the request handshake.
  assign rsp_fire    = bus_rsp_valid &
                       (((state_q == StReq) & bus_req_ready) | (state_q == StWait));
  assign timeout_hit = (TIMEOUT != 0) && (state_q == StWait) && !bus_rsp_valid &&
                       (32'(wait_cnt_q) == TIMEOUT - 1);
  assign fault       = timeout_hit | bus_rsp_err;
  assign in_ready    = (state_q == StIdle);

  lsu_load_align #(
    .XLEN  (XLEN),
    .OFF_W (OFF_W)
  ) u_load_align (
    .rdata  (bus_rsp_rdata),
    .offset (off_q),
    .size   (size_q),
    .sext   (sext_q),
    .data   (load_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      we_q          <= 1'b0;
      size_q        <= 2'd0;
      sext_q        <= 1'b0;
      off_q         <= '0;
      rd_q          <= '0;
      wait_cnt_q    <= '0;
      bus_req_valid <= 1'b0;
      bus_req_we    <= 1'b0;
      bus_req_addr  <= '0;
      bus_req_wdata <= '0;
      bus_req_mask  <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_rd_idx    <= '0;
      out_is_load   <= 1'b0;
      out_exc       <= 1'b0;
      out_exc_cause <= EXC_NONE;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            we_q   <= dec.we;
            size_q <= dec.size;
            sext_q <= dec.sext;
            off_q  <= in_off;
            rd_q   <= in_rd_idx;
            if (!dec.mem) begin
              state_q       <= StDone;
              out_valid     <= 1'b1;
              out_data      <= '0;
              out_rd_idx    <= in_rd_idx;
              out_is_load   <= 1'b0;
              out_exc       <= 1'b0;
              out_exc_cause <= EXC_NONE;
            end
`ifdef LSU_MISALIGN_TRAP_EN
            else if (misalign) begin
              state_q       <= StDone;
              out_valid     <= 1'b1;
              out_data      <= '0;
              out_rd_idx    <= in_rd_idx;
              out_is_load   <= 1'b0;
              out_exc       <= 1'b1;
              out_exc_cause <= dec.we ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
            end
`endif
            else begin
              state_q       <= StReq;
              bus_req_valid <= 1'b1;
              bus_req_we    <= dec.we;
              bus_req_addr  <= req_addr;
              bus_req_wdata <= req_wdata;
              bus_req_mask  <= req_mask;
            end
          end
        end
        StReq: begin
          if (bus_req_ready) begin
            bus_req_valid <= 1'b0;
            wait_cnt_q    <= '0;
            state_q       <= bus_rsp_valid ? StDone : StWait;
          end
        end
        StWait: begin
          if (rsp_fire || timeout_hit) state_q <= StDone;
          else                         wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end
        StDone: begin
          if (out_ready) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (rsp_fire || timeout_hit) begin
        out_valid     <= 1'b1;
        out_rd_idx    <= rd_q;
        out_exc       <= fault;
        out_exc_cause <= fault ? EXC_ACCESS : EXC_NONE;
        out_is_load   <= !fault && !we_q;
        out_data      <= (fault || we_q) ? '0 : load_data;
      end
    end
  end

endmodule
